// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle log-shifter sequencer for SLL/SRL/SRA.
// One power-of-two stage is applied per clock, so every operation spends
// exactly SW cycles in SHIFT no matter what the shift amount is.
module shift_seq_ctrl #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  result,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_cnt;
  logic [N-1:0]  r_data;
  logic [1:0]    r_op;
  logic [SW-1:0] r_shamt;
  logic          r_fill;

  logic          w_accept;
  logic          w_last;
  logic          w_sel;
  logic [N-1:0]  w_stage;

  assign w_accept = (r_state == IDLE) && in_valid && !flush;
  assign w_last   = (r_cnt == SW'(SW - 1));
  // Bit k of the latched amount, selected without a narrow index expression.
  assign w_sel    = |(r_shamt & (SW'(1) << r_cnt));

  // Outputs are decoded from state or taken straight from registers.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; flush returns to IDLE from anywhere.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_accept) w_next = SHIFT;
        SHIFT:   if (w_last) w_next = DONE;
        DONE:    if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // One shifter stage: shift by 2^cnt when the matching amount bit is set.
  // Right shifts OR in the fill bit captured from the original operand.
  always_comb begin
    w_stage = r_data;
    for (int unsigned k = 0; k < SW; k++) begin
      if (w_sel && (r_cnt == k[SW-1:0])) begin
        if (r_op == 2'b00)
          w_stage = r_data << (2 ** k);
        else
          w_stage = (r_data >> (2 ** k)) | ({N{r_fill}} << (N - (2 ** k)));
      end
    end
  end

  // Operand capture, per-stage data update and stage counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_data  <= '0;
      r_op    <= '0;
      r_shamt <= '0;
      r_fill  <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data  <= a;
            r_op    <= op;
            r_shamt <= shamt;
            r_fill  <= (op == 2'b10) && a[N-1];
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_data <= w_stage;
          r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl: directed scenarios plus a randomized
// regression checked against a plain-arithmetic reference model.
module tb_shift_seq_ctrl;

  localparam int N  = 32;
  localparam int SW = 5;
  localparam int LAT = SW;
  localparam int TMO = 60;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [N-1:0]  a;
  logic [SW-1:0] shamt;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;
  logic          busy;

  int errors = 0;
  int checks = 0;

  shift_seq_ctrl #(.N(N), .SW(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_shift(input logic [1:0] o,
                                             input logic [N-1:0] v,
                                             input logic [SW-1:0] s);
    logic signed [N-1:0] sv;
    sv = v;
    case (o)
      2'b00:   return v << s;
      2'b10:   return sv >>> s;
      default: return v >> s;
    endcase
  endfunction

  // Present one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [N-1:0] v, input logic [SW-1:0] s);
    op = o; a = v; shamt = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges from the accept edge until out_valid, bounded by TMO.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic recover();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; shamt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic_sra();
    int lat;
    issue(2'b10, 32'h8000_0000, 5'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sra_busy_after_accept got=%b exp=1", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sra_in_ready_shift got=%b exp=0", in_ready); end
    wait_valid(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL sra_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (result !== 32'hF800_0000) begin errors++; $display("FAIL sra_result got=%h exp=f8000000", result); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sra_busy_done got=%b exp=1", busy); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sra_busy_after_hs got=%b exp=0", busy); end
    if (lat >= TMO) recover();
  endtask

  task automatic test_amounts();
    logic [1:0]    ops [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [N-1:0]  as  [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [SW-1:0] ss  [4] = '{5'd31, 5'd0, 5'd1, 5'd31};
    logic [N-1:0]  exp [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], ss[i]);
      wait_valid(lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL amt_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL amt_result[%0d] got=%h exp=%h", i, result, exp[i]); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (lat >= TMO) recover();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(2'b01, 32'hF000_000F, 5'd8);
    wait_valid(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (result !== 32'h00F0_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] result=%h ov=%b ir=%b exp=00f00000/1/0", i, result, out_valid, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release ov=%b ir=%b exp=0/1", out_valid, in_ready);
    end
    if (lat >= TMO) recover();
  endtask

  task automatic test_input_change();
    int lat;
    logic [N-1:0] exp;
    exp = ref_shift(2'b10, 32'hC3A5_1234, 5'd13);
    issue(2'b10, 32'hC3A5_1234, 5'd13);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      a = $urandom; op = 2'($urandom); shamt = 5'($urandom);
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL chg_latency got=%0d exp=%0d", lat, LAT); end
    a = $urandom; op = 2'($urandom); shamt = 5'($urandom);
    @(negedge clk);
    checks++; if (result !== exp) begin errors++; $display("FAIL chg_result got=%h exp=%h", result, exp); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (lat >= TMO) recover();
  endtask

  task automatic test_flush_reset();
    int lat;
    int seen;
    issue(2'b00, 32'h1234_5678, 5'd3);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_shift busy=%b ir=%b exp=0/1", busy, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_valid got=%0d exp=0", seen); end
    // flush together with a request in IDLE must not accept it
    op = 2'b00; a = 32'h1; shamt = 5'd1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_accept busy=%b exp=0", busy); end
    issue(2'b10, 32'h7FFF_FFFF, 5'd31);
    wait_valid(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL sra_pos_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL sra_pos_result got=%h exp=0", result); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_done ov=%b result=%h ir=%b exp=0/0/1", out_valid, result, in_ready);
    end
    // flush in DONE with out_ready: result withdrawn, block idle
    issue(2'b01, 32'hFFFF_0000, 5'd4);
    wait_valid(lat);
    checks++; if (result !== 32'h0FFF_F000) begin errors++; $display("FAIL flush_done_pre got=%h exp=0ffff000", result); end
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_done ov=%b ir=%b exp=0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [1:0]    o;
    logic [N-1:0]  v;
    logic [SW-1:0] s;
    logic [N-1:0]  exp;
    int lat;
    int fc;
    int gap;
    for (int n = 0; n < 1000; n++) begin
      o = 2'($urandom); v = $urandom; s = 5'($urandom);
      if ($urandom_range(0, 7) == 0) s = (n % 2 == 0) ? 5'd0 : 5'd31;
      exp = ref_shift(o, v, s);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(o, v, s);
      if ($urandom_range(0, 9) == 0) begin
        fc = $urandom_range(0, LAT - 1);
        repeat (fc) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL rnd_flush[%0d] ov=%b busy=%b exp=0/0", n, out_valid, busy);
        end
      end else begin
        wait_valid(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", n, lat, LAT); end
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checks++; if (out_valid !== 1'b1 || result !== exp) begin
            errors++; $display("FAIL rnd_hold[%0d] ov=%b got=%h exp=%h", n, out_valid, result, exp);
          end
        end
        checks++; if (result !== exp) begin
          errors++; $display("FAIL rnd_result[%0d] op=%0d a=%h sh=%0d got=%h exp=%h", n, o, v, s, result, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (lat >= TMO) recover();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sra();
    test_amounts();
    test_backpressure();
    test_input_change();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the ALU shift path. Executes SLL, SRL or SRA as a log-shifter, one power-of-two stage per clock, instead of a full single-cycle barrel shifter.
- Sits beside the ALU. The execute stage hands it one operation over a valid/ready handshake and collects the result over a second valid/ready handshake.
- Trades area for fixed multi-cycle latency.

Parameters:
- N, 32: operand/result width; power of two, ≥ 4.
- SW, $clog2(N) (5 at default): shift-amount width, equal to the stage count.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous abort of any in-flight op
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 treated as SRL
- a  input  N  operand to shift
- shamt  input  SW  shift amount; upper operand bits are ignored upstream
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  N  shifted value
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at an edge, priority over everything):
  - state=IDLE, stage counter=0, data register=0, latched op/shamt=0.
  - out_valid=0, result=0, in_ready=1, busy=0.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready && !flush: latch a into the data register; latch op, shamt and fill bit (a[N-1] if op==10, else 0); set cnt=0; go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge processes stage k=cnt. If latched shamt[k]=1, shift the data register by 2^k:
    - left for SLL, zero fill;
    - right for SRL/SRA, filled with the latched fill bit.
  - If shamt[k]=0, hold the data register.
  - cnt increments. On the edge processing k=SW-1, go to DONE.
- Latency and rate:
  - Fixed SW cycles in SHIFT regardless of shamt value, including shamt=0.
  - Acceptance at edge E0 gives out_valid=1 after edge E0+SW (E5 at default).
  - Throughput is one op per SW+2 cycles minimum.
- DONE:
  - out_valid=1; result = data register.
  - result holds stable while out_valid=1 && out_ready=0; back-pressure may last indefinitely.
  - On out_ready=1: go to IDLE and clear out_valid at that edge.
  - in_ready=0 in DONE. There is no same-cycle re-accept.
- Flush (when rst=0):
  - From any state, go to IDLE at that edge; out_valid clears, cnt=0.
  - The result is discarded and never presented.
  - flush with in_valid in IDLE: no accept.
  - flush in DONE with out_ready=1: the handshake does not count as completed.
- Input stability:
  - a/op/shamt are sampled only at the accept edge.
  - Changes during SHIFT/DONE have no effect.
- Arithmetic:
  - Result equals a<<shamt, a>>shamt, or $signed(a)>>>shamt, truncated to N bits.
  - shamt=N-1 is the largest shift.
  - SRA of a negative value with shamt=N-1 yields all ones.
- Fill source: the fill bit comes from the latched original a[N-1], not from the evolving register. This is identical for SRA.

Test Plan:
- Basic SRA: rst for 2 cycles → outputs 0, in_ready=1. Then op=10, a=0x8000_0000, shamt=4, in_valid pulse → out_valid high exactly 5 cycles after accept, result=0xF800_0000, busy high from accept edge until handshake.
- Zero and max amounts:
  - op=00, a=0x0000_0001, shamt=31 → result=0x8000_0000.
  - op=01, a=0xFFFF_FFFF, shamt=0 → result=0xFFFF_FFFF, still 5-cycle latency.
  - op=11, a=0x8000_0000, shamt=1 → result=0x4000_0000 (treated as SRL).
- Back-pressure: op=01, a=0xF000_000F, shamt=8, out_ready=0 for 10 cycles → result=0x00F0_0000 held stable, in_ready=0 throughout. Raise out_ready → out_valid drops next edge, in_ready returns 1.
- Input changes in flight: change a/shamt/op every cycle during SHIFT → result reflects the accept-edge values only.
- Flush and reset mid-op:
  - flush at 3rd SHIFT cycle → IDLE next edge, no out_valid ever.
  - Next op=10, a=0x7FFF_FFFF, shamt=31 → result=0x0000_0000.
  - rst asserted in DONE → out_valid=0, result=0 next edge.
- Random regression: 1000 random a/op/shamt with random out_ready gaps and occasional flush, checked against the reference model for values and exact latency.
